m_coeff_stream: RTL and testbench

Downstream stage of the message encoder: snapshots the encoder's 2048-bit parallel coefficient vector when encoding completes, then streams the 256 8-bit coefficients out one per handshake. Its output feeds the serial polynomial datapath (ciphertext `v` accumulation). An optional compiled-in adder sums each coefficient with an aligned incoming `v` coefficient mod 256.

---
 rtl/m_pkg.sv | 15 +
 rtl/m_coeff_sel.sv | 36 +++
 rtl/m_coeff_stream.sv | 104 ++++++++++
 tb/tb_m_coeff_stream.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/m_pkg.sv
// Shared sizes and state encoding for the coefficient streaming stage.
package m_pkg;

  localparam int unsigned N_COEFF = 256;
  localparam int unsigned COEFF_W = 8;
  localparam int unsigned VEC_W   = N_COEFF * COEFF_W;
  localparam int unsigned IDX_W   = $clog2(N_COEFF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } m_cs_state_t;

endpackage

// File: rtl/m_coeff_sel.sv
// 256:1 coefficient selector from the captured vector; optional mod-256 adder
// of the aligned v coefficient when M_COEFF_ADD_EN is defined.
module m_coeff_sel
  import m_pkg::*;
(
  input  logic [0:VEC_W-1]   buf_i,
  input  logic [IDX_W-1:0]   idx_i,
`ifdef M_COEFF_ADD_EN
  input  logic [COEFF_W-1:0] v_i,
`endif
  output logic [COEFF_W-1:0] coeff_o
);

  logic [COEFF_W-1:0] coeff_arr [N_COEFF];
  logic [COEFF_W-1:0] sel;

  // Coefficient k occupies buf_i[8k:8k+7] with bit 8k as MSB.
  for (genvar k = 0; k < int'(N_COEFF); k++) begin : g_split
    assign coeff_arr[k] = buf_i[k*COEFF_W +: COEFF_W];
  end

  always_comb begin
    sel = coeff_arr[idx_i];
  end

`ifdef M_COEFF_ADD_EN
  always_comb begin
    coeff_o = sel + v_i;
  end
`else
  always_comb begin
    coeff_o = sel;
  end
`endif

endmodule

// File: rtl/m_coeff_stream.sv
// Snapshots the encoder coefficient vector on the falling edge of compute and
// streams it out one coefficient per handshake. Optional adder: M_COEFF_ADD_EN.
module m_coeff_stream
  import m_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:VEC_W-1]     m_in,
  input  logic                 compute,
  input  logic                 coeff_ready,
`ifdef M_COEFF_ADD_EN
  input  logic [COEFF_W-1:0]   v_in,
`endif
  output logic [COEFF_W-1:0]   coeff_out,
  output logic                 coeff_valid,
  output logic [IDX_W-1:0]     coeff_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  m_cs_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [0:VEC_W-1]   buf_q, buf_d;
  logic               compute_q;
  logic               overrun_q, overrun_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               capture_c;

  assign capture_c = compute_q & ~compute;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      buf_q     <= '0;
      compute_q <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      compute_q <= compute;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state: capture in IDLE, walk idx on handshakes, one-cycle DONE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (capture_c) begin
          buf_d   = m_in;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (capture_c) overrun_d = 1'b1;
        if (valid_q && coeff_ready) begin
          if (idx_q == IDX_W'(N_COEFF - 1)) state_d = DONE;
          else                              idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (capture_c) overrun_d = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == STREAM);
    busy_d  = (state_d == STREAM);
    done_d  = (state_d == DONE);
  end

  m_coeff_sel u_sel (
    .buf_i   (buf_q),
    .idx_i   (idx_q),
`ifdef M_COEFF_ADD_EN
    .v_i     (v_in),
`endif
    .coeff_o (coeff_out)
  );

  assign coeff_valid = valid_q;
  assign coeff_idx   = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_m_coeff_stream.sv
// Scoreboard bench for m_coeff_stream: expected (idx, value) pairs are queued at
// capture and popped on every observed handshake.
module tb_m_coeff_stream;
  import m_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [0:VEC_W-1]     m_in;
  logic                 compute;
  logic                 coeff_ready;
  logic [COEFF_W-1:0]   coeff_out;
  logic                 coeff_valid;
  logic [IDX_W-1:0]     coeff_idx;
  logic                 busy;
  logic                 done;
  logic                 overrun;
  logic [7:0]           vin_val = 8'd0;
`ifdef M_COEFF_ADD_EN
  logic [COEFF_W-1:0]   v_in;
  assign v_in = vin_val;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb_q [$];

  always #5 clk = ~clk;

  m_coeff_stream dut (
    .clk         (clk),
    .reset       (reset),
    .m_in        (m_in),
    .compute     (compute),
    .coeff_ready (coeff_ready),
`ifdef M_COEFF_ADD_EN
    .v_in        (v_in),
`endif
    .coeff_out   (coeff_out),
    .coeff_valid (coeff_valid),
    .coeff_idx   (coeff_idx),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  // Encoder reset vector is coeff i = (383 - i) mod 256; off=128 gives all-ones message.
  function automatic logic [7:0] enc_coeff(input int k, input int off);
    return 8'((383 - k + off) % 256);
  endfunction

  task automatic load_msg(input int off);
    logic [7:0] c;
    for (int k = 0; k < 256; k++) begin
      c = enc_coeff(k, off);
      m_in[k*8 +: 8] = c;
      sb_q.push_back({8'(k), 8'(c + vin_val)});
    end
  endtask

  task automatic capture();
    compute = 1'b1;
    @(negedge clk);
    compute = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; compute = 1'b0; coeff_ready = 1'b1; m_in = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (coeff_out !== 8'd0) begin n_err++; $display("FAIL rst_out got %0d want 0", coeff_out); end
    n_cmp++; if (coeff_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", coeff_valid); end
    n_cmp++; if (coeff_idx !== 8'd0) begin n_err++; $display("FAIL rst_idx got %0d want 0", coeff_idx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got %b want 0", overrun); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (coeff_valid !== 1'b0 || coeff_idx !== 8'd0) begin
      n_err++; $display("FAIL idle_ready got valid=%b idx=%0d want valid=0 idx=0", coeff_valid, coeff_idx);
    end
  endtask

  // Full capture + stream; duty>1 asserts ready 1-in-duty cycles; ov_at>=0 injects a
  // second compute falling edge while coefficient ov_at is current.
  task automatic test_stream(input string name, input int off, input int duty, input int ov_at);
    int hs = 0, cyc = 0, ov_phase = 0;
    logic stalled = 1'b0;
    logic [7:0] held_out = '0, held_idx = '0;
    logic [15:0] e;
    load_msg(off);
    capture();
    while (hs < 256 && cyc < 4000) begin
      coeff_ready = (duty <= 1) ? 1'b1 : ((cyc % duty) == 0);
      if (ov_phase == 1) begin compute = 1'b0; ov_phase = 2; end
      else if (ov_phase == 2) begin
        ov_phase = 3;
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL %s overrun_set got %b want 1", name, overrun); end
      end
      if (ov_at >= 0 && ov_phase == 0 && hs == ov_at) begin
        compute = 1'b1; m_in = ~m_in; ov_phase = 1;
      end
      if (stalled && coeff_valid) begin
        n_cmp++; if (coeff_out !== held_out || coeff_idx !== held_idx) begin
          n_err++; $display("FAIL %s stall_hold got out=%0d idx=%0d want out=%0d idx=%0d",
                            name, coeff_out, coeff_idx, held_out, held_idx);
        end
      end
      if (coeff_valid && coeff_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL %s sb_empty got handshake %0d want none", name, hs);
        end else begin
          e = sb_q.pop_front();
          n_cmp++; if (coeff_out !== e[7:0] || coeff_idx !== e[15:8] || busy !== 1'b1) begin
            n_err++; $display("FAIL %s coeff got out=%0d idx=%0d busy=%b want out=%0d idx=%0d busy=1",
                              name, coeff_out, coeff_idx, busy, e[7:0], e[15:8]);
          end
        end
        hs++;
      end
      stalled  = coeff_valid && !coeff_ready;
      held_out = coeff_out;
      held_idx = coeff_idx;
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (hs != 256) begin n_err++; $display("FAIL %s handshakes got %0d want 256", name, hs); end
    if (duty <= 1) begin
      n_cmp++; if (cyc != 257) begin n_err++; $display("FAIL %s latency got %0d want 257", name, cyc); end
    end
    n_cmp++; if (done !== 1'b1 || coeff_valid !== 1'b0) begin
      n_err++; $display("FAIL %s done_pulse got done=%b valid=%b want done=1 valid=0", name, done, coeff_valid);
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s done_clear got done=%b busy=%b want 0 0", name, done, busy);
    end
    n_cmp++; if (overrun !== (ov_at >= 0)) begin
      n_err++; $display("FAIL %s overrun_end got %b want %b", name, overrun, ov_at >= 0);
    end
  endtask

  task automatic test_mid_reset();
    int hs = 0, cyc = 0;
    load_msg(0);
    capture();
    coeff_ready = 1'b1;
    while (hs < 100 && cyc < 400) begin
      if (coeff_valid && coeff_ready) begin void'(sb_q.pop_front()); hs++; end
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (coeff_idx !== 8'd100) begin n_err++; $display("FAIL mr_pre_idx got %0d want 100", coeff_idx); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({coeff_out, coeff_valid, coeff_idx, busy, done, overrun} !== 20'd0) begin
      n_err++; $display("FAIL mr_abort got out=%0d valid=%b idx=%0d busy=%b done=%b ovr=%b want all 0",
                        coeff_out, coeff_valid, coeff_idx, busy, done, overrun);
    end
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || coeff_valid !== 1'b0) begin
      n_err++; $display("FAIL mr_no_done got done=%b valid=%b want 0 0", done, coeff_valid);
    end
    test_stream("restart", 0, 1, -1);
  endtask

`ifdef M_COEFF_ADD_EN
  task automatic test_add();
    vin_val = 8'd200;
    test_stream("add", 0, 1, -1);
    vin_val = 8'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream("enc_reset_vec", 0, 1, -1);
    test_stream("all_ones", 128, 1, -1);
    test_stream("stall", 0, 3, -1);
    test_stream("overrun", 0, 1, 40);
    test_mid_reset();
`ifdef M_COEFF_ADD_EN
    test_add();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
